// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types, defaults and round-robin pick for mul_share_arbiter
package mul_share_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_A_W     = 11;
  localparam int DEF_B_W     = 12;
  localparam int DEF_P_W     = DEF_A_W + DEF_B_W;
  localparam int DEF_MUL_LAT = 3;
  localparam int N_MAX       = 8;
  localparam int TAG_W       = $clog2(DEF_N_REQ);

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // First requester at or after ptr (wrapping at n) wins; result is one-hot or zero.
  function automatic logic [N_MAX-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                               input logic [2:0] ptr,
                                               input int n);
    logic [N_MAX-1:0] g;
    logic [2:0]       idx;
    g = '0;
    for (int k = N_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (req[idx]) begin
          g      = '0;
          g[idx] = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - requester/response bus between kernels and the multiplier share block
interface mul_share_arbiter_if
  import mul_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int P_W   = DEF_P_W
);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic [N_REQ-1:0]     rsp_valid;
  logic [N_REQ-1:0]     rsp_ready;
  logic [P_W-1:0]       rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p
  );

endinterface

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rtl/mul_share_arbiter_rr_arbiter.sv - round-robin grant with a pointer that moves past each winner
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int N = DEF_N_REQ
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]    ptr;
  logic [N_MAX-1:0] pick;
  logic             pick_unused;

  always_comb begin
    pick  = rr_pick(N_MAX'(req), 3'(ptr), N);
    grant = pick[N-1:0];
  end

  assign pick_unused = ^pick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) ptr <= PW'((i + 1) % N);
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - shares one ce-gated pipelined multiplier among N_REQ requesters
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int P_W     = DEF_P_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  mul_share_arbiter_if.slave             bus,
  output logic                           mul_ce,
  output logic [A_W-1:0]                 mul_a,
  output logic [B_W-1:0]                 mul_b,
  input  logic [P_W-1:0]                 mul_p,
  output logic [$clog2(MUL_LAT+2)-1:0]   inflight,
  output logic                           idle
);

  localparam int IW = $clog2(MUL_LAT + 2);

  // Stage 0 is the issue register; stages 1..MUL_LAT shadow the un-reset multiplier pipe.
  stage_t           chain [0:MUL_LAT];
  stage_t           head;
  logic             head_ready;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] rsp_valid_c;
  logic [TAG_W-1:0] grant_tag;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [IW-1:0]    cnt;

  assign head = chain[MUL_LAT];

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .advance (mul_ce),
    .grant   (grant)
  );

  always_comb begin
    head_ready  = 1'b0;
    grant_tag   = '0;
    sel_a       = '0;
    sel_b       = '0;
    rsp_valid_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head.tag == TAG_W'(i)) head_ready = bus.rsp_ready[i];
      rsp_valid_c[i] = head.v && (head.tag == TAG_W'(i));
      if (grant[i]) begin
        grant_tag = TAG_W'(i);
        sel_a     = bus.req_a[i*A_W +: A_W];
        sel_b     = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  // One ce freezes the whole multiplier, so a stalled head stalls every stage and all issue.
  assign mul_ce        = !head.v || head_ready;
  assign bus.req_ready = grant & {N_REQ{mul_ce}};
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_p     = mul_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s <= MUL_LAT; s++) chain[s] <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (mul_ce) begin
      chain[0] <= '{v: |grant, tag: grant_tag};
      for (int s = 1; s <= MUL_LAT; s++) chain[s] <= chain[s-1];
      if (|grant) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int s = 0; s <= MUL_LAT; s++) cnt = cnt + IW'(chain[s].v);
  end

  assign inflight = cnt;
  assign idle     = (cnt == '0) && !(|bus.req_valid);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mul_ce;
  logic [10:0] mul_a;
  logic [11:0] mul_b;
  logic [22:0] mul_p;
  logic [2:0]  inflight;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_tag[$];
  int exp_p[$];

  mul_share_arbiter_if #(.N_REQ(4), .A_W(11), .B_W(12), .P_W(23)) bus ();

  mul_share_arbiter #(.N_REQ(4), .A_W(11), .B_W(12), .P_W(23), .MUL_LAT(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .mul_ce   (mul_ce),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
    .inflight (inflight),
    .idle     (idle)
  );

  // Behavioural stand-in for the shared 3-register multiplier, deliberately un-reset.
  logic [10:0] m_a;
  logic [11:0] m_b;
  logic [22:0] m_tmp;
  always @(posedge clk) begin
    if (mul_ce) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_tmp <= m_a * m_b;
      mul_p <= m_tmp;
    end
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input int a, input int b);
    bus.req_a[r*11 +: 11] = 11'(a);
    bus.req_b[r*12 +: 12] = 12'(b);
  endtask

  // Every accepted result must match the next hand-computed expectation in issue order.
  always @(negedge clk) begin
    if (reset_n && |(bus.rsp_valid & bus.rsp_ready)) begin
      if (exp_p.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        int t, p;
        t = exp_tag.pop_front();
        p = exp_p.pop_front();
        check("rsp_owner", 32'(bus.rsp_valid), 32'(1 << t));
        check("rsp_product", 32'(bus.rsp_p), 32'(p));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int prod_rr[4];
    int ext_a[3];
    int ext_b[3];
    int ext_p[3];
    prod_rr = '{1000, 1111, 1224, 1339};
    ext_a   = '{2047, 0, 1};
    ext_b   = '{4095, 4095, 1};
    ext_p   = '{8382465, 0, 1};

    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    #3;
    check("reset_req_ready", 32'(bus.req_ready), 0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_mul_ce", 32'(mul_ce), 1);
    check("reset_inflight", 32'(inflight), 0);
    check("reset_idle", 32'(idle), 1);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // single op from requester 1
    set_op(1, 100, 200);
    bus.req_valid = 4'b0010;
    exp_tag.push_back(1); exp_p.push_back(20000);
    #1 check("single_ready", 32'(bus.req_ready), 32'b0010);
    check("single_idle_busy", 32'(idle), 0);
    cyc();
    bus.req_valid = '0;
    #1 check("single_inflight", 32'(inflight), 1);
    cyc(); cyc();
    #1 check("single_not_yet", 32'(bus.rsp_valid), 0);
    cyc();
    #1 check("single_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    check("single_rsp_p", 32'(bus.rsp_p), 20000);
    cyc();
    #1 check("single_drained", 32'(inflight), 0);
    check("single_idle", 32'(idle), 1);

    // extreme operands back-to-back from requester 3
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      set_op(3, ext_a[k], ext_b[k]);
      exp_tag.push_back(3); exp_p.push_back(ext_p[k]);
      #1 check("ext_ready", 32'(bus.req_ready), 32'b1000);
      cyc();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1 check("ext_rsp_p", 32'(bus.rsp_p), 32'(ext_p[k]));
      check("ext_rsp_valid", 32'(bus.rsp_valid), 32'b1000);
    end
    cyc();
    #1 check("ext_drained", 32'(inflight), 0);

    // round-robin fairness, all four requesting
    for (int r = 0; r < 4; r++) set_op(r, 10 + r, 100 + r);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      exp_tag.push_back(k % 4); exp_p.push_back(prod_rr[k % 4]);
      #1 check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      cyc();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) cyc();
    #1 check("rr_drained", 32'(inflight), 0);
    check("rr_scoreboard_empty", 32'(exp_p.size()), 0);

    // back-pressure on the head owner
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      exp_tag.push_back(k); exp_p.push_back(prod_rr[k]);
      #1 check("bp_grant", 32'(bus.req_ready), 32'(1 << k));
      cyc();
    end
    for (int s = 0; s < 5; s++) begin
      #1 check("bp_mul_ce", 32'(mul_ce), 0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
      check("bp_rsp_p", 32'(bus.rsp_p), 1000);
      check("bp_inflight", 32'(inflight), 4);
      cyc();
    end
    bus.rsp_ready = 4'b1111;
    bus.req_valid = '0;
    #1 check("bp_release_ce", 32'(mul_ce), 1);
    check("bp_release_valid", 32'(bus.rsp_valid), 32'b0001);
    for (int k = 1; k < 4; k++) begin
      cyc();
      #1 check("bp_after_valid", 32'(bus.rsp_valid), 32'(1 << k));
      check("bp_after_p", 32'(bus.rsp_p), 32'(prod_rr[k]));
    end
    cyc();
    #1 check("bp_drained", 32'(inflight), 0);

    // asynchronous reset with three ops in flight
    bus.req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1 check("rst_grant", 32'(bus.req_ready), 32'(1 << k));
      cyc();
    end
    bus.req_valid = '0;
    #1 check("rst_pre_inflight", 32'(inflight), 3);
    #1 reset_n = 1'b0;
    #1 check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_mul_ce", 32'(mul_ce), 1);
    check("rst_idle", 32'(idle), 1);
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1 check("rst_no_stale", 32'(bus.rsp_valid), 0);
    end
    set_op(0, 3, 7);
    bus.req_valid = 4'b0001;
    exp_tag.push_back(0); exp_p.push_back(21);
    #1 check("rst_next_ready", 32'(bus.req_ready), 32'b0001);
    cyc();
    bus.req_valid = '0;
    cyc(); cyc(); cyc();
    #1 check("rst_next_p", 32'(bus.rsp_p), 21);
    check("rst_next_valid", 32'(bus.rsp_valid), 32'b0001);
    cyc();

    // head retire and new issue in the same cycle
    set_op(0, 5, 6);
    bus.req_valid = 4'b0001;
    exp_tag.push_back(0); exp_p.push_back(30);
    #1 check("ri_first_ready", 32'(bus.req_ready), 32'b0001);
    cyc();
    bus.req_valid = '0;
    cyc(); cyc(); cyc();
    set_op(2, 10, 10);
    bus.req_valid = 4'b0100;
    exp_tag.push_back(2); exp_p.push_back(100);
    #1 check("ri_head_valid", 32'(bus.rsp_valid), 32'b0001);
    check("ri_ready", 32'(bus.req_ready), 32'b0100);
    check("ri_inflight_before", 32'(inflight), 1);
    cyc();
    bus.req_valid = '0;
    #1 check("ri_inflight_after", 32'(inflight), 1);
    check("ri_gap", 32'(bus.rsp_valid), 0);
    cyc(); cyc(); cyc();
    #1 check("ri_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
    check("ri_rsp_p", 32'(bus.rsp_p), 100);
    cyc();
    #1 check("ri_drained", 32'(inflight), 0);
    check("ri_idle", 32'(idle), 1);
    check("scoreboard_empty", 32'(exp_p.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
